// File: rtl/atm_bank.sv
// rtl/atm_bank.sv - multi-account ATM controller with a fixed-latency request/response FSM
// Optional wrong-PIN lockout is enabled by defining ATM_LOCKOUT_EN.
module atm_bank #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int BAL_W        = 16,
  parameter int PIN_W        = 4,
  parameter int INIT_BAL     = 1000,
  parameter int DEFAULT_PIN  = 5,
  parameter int MAX_TRIES    = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              acct_id,
  input  logic [1:0]              operation,
  input  logic [BAL_W-1:0]        amount,
  input  logic [PIN_W-1:0]        pin,
  output logic                    resp_valid,
  output logic [2:0]              resp_status,
  output logic [BAL_W-1:0]        resp_balance,
  output logic [NUM_ACCOUNTS-1:0] locked
);

  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;

  localparam logic [2:0] ST_OK       = 3'b000;
  localparam logic [2:0] ST_BAD_PIN  = 3'b001;
  localparam logic [2:0] ST_LOCKED   = 3'b010;
  localparam logic [2:0] ST_INSUFF   = 3'b011;
  localparam logic [2:0] ST_OVERFLOW = 3'b100;
  localparam logic [2:0] ST_BAD_ACCT = 3'b101;

  typedef enum logic [1:0] {IDLE, VERIFY, EXEC, RESP} state_t;

  state_t             state;
  logic [7:0]         cur_acct;
  logic [1:0]         cur_op;
  logic [BAL_W-1:0]   cur_amt;
  logic [PIN_W-1:0]   cur_pin;
  logic [2:0]         verdict;
  logic [BAL_W-1:0]   bal  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]   pins [NUM_ACCOUNTS];

  logic [IDX_W-1:0]   idx;
  logic               acct_ok;
  logic               lock_hit;
  logic [2:0]         check;
  logic [BAL_W:0]     sum;
  logic [BAL_W-1:0]   diff;

`ifdef ATM_LOCKOUT_EN
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  logic [CNT_W-1:0]        fail_cnt [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_r;
  assign lock_hit = lock_r[idx];
  assign locked   = lock_r;
`else
  assign lock_hit = 1'b0;
  assign locked   = '0;
`endif

  assign idx     = cur_acct[IDX_W-1:0];
  assign acct_ok = 32'(cur_acct) < NUM_ACCOUNTS;
  assign sum     = {1'b0, bal[idx]} + {1'b0, cur_amt};
  assign diff    = bal[idx] - cur_amt;

  // Priority: bad account, then lockout, then PIN.
  always_comb begin
    check = ST_OK;
    if (!acct_ok)                  check = ST_BAD_ACCT;
    else if (lock_hit)             check = ST_LOCKED;
    else if (pins[idx] != cur_pin) check = ST_BAD_PIN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_status  <= ST_OK;
      resp_balance <= '0;
      cur_acct     <= '0;
      cur_op       <= '0;
      cur_amt      <= '0;
      cur_pin      <= '0;
      verdict      <= ST_OK;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i]  <= BAL_W'(INIT_BAL);
        pins[i] <= PIN_W'(DEFAULT_PIN);
`ifdef ATM_LOCKOUT_EN
        fail_cnt[i] <= '0;
`endif
      end
`ifdef ATM_LOCKOUT_EN
      lock_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_acct  <= acct_id;
            cur_op    <= operation;
            cur_amt   <= amount;
            cur_pin   <= pin;
            req_ready <= 1'b0;
            state     <= VERIFY;
          end
        end
        VERIFY: begin
          verdict <= check;
          state   <= EXEC;
        end
        EXEC: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          if (verdict != ST_OK) begin
            resp_status  <= verdict;
            resp_balance <= '0;
`ifdef ATM_LOCKOUT_EN
            if (verdict == ST_BAD_PIN) begin
              if (fail_cnt[idx] < CNT_W'(MAX_TRIES)) fail_cnt[idx] <= fail_cnt[idx] + 1'b1;
              if (fail_cnt[idx] + 1'b1 >= CNT_W'(MAX_TRIES)) lock_r[idx] <= 1'b1;
            end
`endif
          end else begin
`ifdef ATM_LOCKOUT_EN
            fail_cnt[idx] <= '0;
`endif
            resp_status  <= ST_OK;
            resp_balance <= bal[idx];
            case (cur_op)
              2'b01: begin
                if (sum[BAL_W]) begin
                  resp_status <= ST_OVERFLOW;
                end else begin
                  bal[idx]     <= sum[BAL_W-1:0];
                  resp_balance <= sum[BAL_W-1:0];
                end
              end
              2'b10: begin
                if (cur_amt > bal[idx]) begin
                  resp_status <= ST_INSUFF;
                end else begin
                  bal[idx]     <= diff;
                  resp_balance <= diff;
                end
              end
              2'b11:   pins[idx] <= cur_amt[PIN_W-1:0];
              default: ;
            endcase
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
